// File: rtl/pilot_ins_pkg.sv
// rtl/pilot_ins_pkg.sv - shared constants, FSM encoding and saturation helpers for pilot_inserter
package pilot_ins_pkg;

  localparam logic [7:0] SR_PILOT_LEVEL_DEF = 8'd128;
  localparam logic [7:0] SR_PILOT_CTRL_DEF  = 8'd129;

  localparam int SAMPLE_W = 16;
  localparam int IQ_W     = 2 * SAMPLE_W;
  localparam int I_MSB    = 31;
  localparam int I_LSB    = 16;
  localparam int Q_MSB    = 15;
  localparam int Q_LSB    = 0;

  typedef enum logic {
    ST_SOP = 1'b0,
    ST_MID = 1'b1
  } state_e;

  // Two's-complement overflow of a 17-bit sum shows up as the two top bits disagreeing.
  function automatic logic sat17_ovf(input logic [SAMPLE_W:0] x);
    return x[SAMPLE_W] ^ x[SAMPLE_W-1];
  endfunction

  function automatic logic [SAMPLE_W-1:0] sat16(input logic [SAMPLE_W:0] x);
    logic [SAMPLE_W-1:0] r;
    if (sat17_ovf(x)) begin
      r = x[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else begin
      r = x[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pilot_inserter_sat_add16.sv
// rtl/pilot_inserter_sat_add16.sv - output stage: registered 17-bit I + level add with clamp and saturation flag
module sat_add16
  import pilot_ins_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ld_i,
  input  logic                valid_i,
  input  logic [IQ_W-1:0]     data_i,
  input  logic                last_i,
  input  logic [SAMPLE_W-1:0] level_i,
  input  logic                add_en_i,
  output logic                valid_o,
  output logic [IQ_W-1:0]     data_o,
  output logic                last_o,
  output logic                sat_o
);

  logic [SAMPLE_W:0]   sum;
  logic [SAMPLE_W-1:0] i_d;
  logic                sat_d;

  always_comb begin
    sum   = {data_i[I_MSB], data_i[I_MSB:I_LSB]} + {level_i[SAMPLE_W-1], level_i};
    i_d   = data_i[I_MSB:I_LSB];
    sat_d = 1'b0;
    if (add_en_i) begin
      i_d   = sat16(sum);
      sat_d = sat17_ovf(sum);
    end
  end

  // A bubble load clears valid but leaves the last data in place.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
      sat_o   <= 1'b0;
    end else if (ld_i) begin
      valid_o <= valid_i;
      if (valid_i) begin
        data_o <= {i_d, data_i[Q_MSB:Q_LSB]};
        last_o <= last_i;
        sat_o  <= sat_d;
      end
    end
  end

endmodule

// File: rtl/pilot_inserter.sv
// rtl/pilot_inserter.sv - ATSC 8-VSB pilot inserter: adds a saturating DC offset to I of a {I,Q} stream.
// Optional saturation event counter enabled by PILOT_INS_SAT_CNT_EN.
module pilot_inserter
  import pilot_ins_pkg::*;
#(
  parameter logic [7:0] SR_PILOT_LEVEL = SR_PILOT_LEVEL_DEF,
  parameter logic [7:0] SR_PILOT_CTRL  = SR_PILOT_CTRL_DEF
) (
  input  logic        ce_clk,
  input  logic        ce_rst,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] s_axis_data_tdata,
  input  logic        s_axis_data_tlast,
  input  logic        s_axis_data_tvalid,
  output logic        s_axis_data_tready,
  output logic [31:0] m_axis_data_tdata,
  output logic        m_axis_data_tlast,
  output logic        m_axis_data_tvalid,
  input  logic        m_axis_data_tready,
  output logic [31:0] sat_count
);

  state_e state_q, state_d;

  logic [SAMPLE_W-1:0] shadow_level_q, active_level_q;
  logic                shadow_en_q, active_en_q;

  logic                v1_q;
  logic [IQ_W-1:0]     data1_q;
  logic                last1_q;
  logic [SAMPLE_W-1:0] level1_q;
  logic                en1_q;

  logic                v2, sat2, ld1, ld2, s_fire;
  logic                wr_level, wr_ctrl;
  logic                sop, load_active;
  logic [SAMPLE_W-1:0] beat_level;
  logic                beat_en;

  assign ld2    = ~v2 | m_axis_data_tready;
  assign ld1    = ~v1_q | ld2;
  assign s_axis_data_tready = ~ce_rst & ld1;
  assign s_fire = s_axis_data_tvalid & s_axis_data_tready;

  assign wr_level = set_stb & (set_addr == SR_PILOT_LEVEL);
  assign wr_ctrl  = set_stb & (set_addr == SR_PILOT_CTRL);

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      shadow_level_q <= '0;
      shadow_en_q    <= 1'b0;
    end else begin
      if (wr_level) shadow_level_q <= set_data[SAMPLE_W-1:0];
      if (wr_ctrl)  shadow_en_q    <= set_data[0];
    end
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) state_q <= ST_SOP;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SOP:  if (s_fire && !s_axis_data_tlast) state_d = ST_MID;
      ST_MID:  if (s_fire && s_axis_data_tlast)  state_d = ST_SOP;
      default: state_d = ST_SOP;
    endcase
  end

  // The first beat of a packet sees the shadow value directly, since active only catches up at this edge.
  always_comb begin
    sop         = (state_q == ST_SOP);
    load_active = sop & s_fire;
    beat_level  = sop ? shadow_level_q : active_level_q;
    beat_en     = sop ? shadow_en_q    : active_en_q;
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      active_level_q <= '0;
      active_en_q    <= 1'b0;
    end else if (load_active) begin
      active_level_q <= shadow_level_q;
      active_en_q    <= shadow_en_q;
    end
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      v1_q     <= 1'b0;
      data1_q  <= '0;
      last1_q  <= 1'b0;
      level1_q <= '0;
      en1_q    <= 1'b0;
    end else begin
      if (ld1) v1_q <= s_axis_data_tvalid;
      if (s_fire) begin
        data1_q  <= s_axis_data_tdata;
        last1_q  <= s_axis_data_tlast;
        level1_q <= beat_level;
        en1_q    <= beat_en;
      end
    end
  end

  sat_add16 u_s2 (
    .clk_i    (ce_clk),
    .rst_i    (ce_rst),
    .ld_i     (ld2),
    .valid_i  (v1_q),
    .data_i   (data1_q),
    .last_i   (last1_q),
    .level_i  (level1_q),
    .add_en_i (en1_q),
    .valid_o  (v2),
    .data_o   (m_axis_data_tdata),
    .last_o   (m_axis_data_tlast),
    .sat_o    (sat2)
  );

  assign m_axis_data_tvalid = v2;

`ifdef PILOT_INS_SAT_CNT_EN
  logic [31:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (wr_ctrl && set_data[1]) begin
      sat_cnt_d = '0;
    end else if (v2 && m_axis_data_tready && sat2 && (sat_cnt_q != 32'hFFFF_FFFF)) begin
      sat_cnt_d = sat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;

  logic unused_set_hi;
  assign unused_set_hi = ^set_data[31:16];
`else
  assign sat_count = 32'd0;

  logic unused_cnt_inputs;
  assign unused_cnt_inputs = ^{set_data[31:16], sat2};
`endif

endmodule

// File: tb/tb_pilot_inserter.sv
// tb/tb_pilot_inserter.sv - directed and table-driven self-checking bench for pilot_inserter
module tb_pilot_inserter;

  localparam logic [7:0] A_LEVEL = 8'd128;
  localparam logic [7:0] A_CTRL  = 8'd129;

`ifdef PILOT_INS_SAT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic [31:0] s_axis_data_tdata = 32'd0;
  logic        s_axis_data_tlast = 1'b0;
  logic        s_axis_data_tvalid = 1'b0;
  logic        s_axis_data_tready;
  logic [31:0] m_axis_data_tdata;
  logic        m_axis_data_tlast;
  logic        m_axis_data_tvalid;
  logic        m_axis_data_tready = 1'b1;
  logic [31:0] sat_count;

  int checks = 0;
  int failures = 0;

  pilot_inserter dut (
    .ce_clk             (ce_clk),
    .ce_rst             (ce_rst),
    .set_stb            (set_stb),
    .set_addr           (set_addr),
    .set_data           (set_data),
    .s_axis_data_tdata  (s_axis_data_tdata),
    .s_axis_data_tlast  (s_axis_data_tlast),
    .s_axis_data_tvalid (s_axis_data_tvalid),
    .s_axis_data_tready (s_axis_data_tready),
    .m_axis_data_tdata  (m_axis_data_tdata),
    .m_axis_data_tlast  (m_axis_data_tlast),
    .m_axis_data_tvalid (m_axis_data_tvalid),
    .m_axis_data_tready (m_axis_data_tready),
    .sat_count          (sat_count)
  );

  always #5 ce_clk = ~ce_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [32:0] got_q[$];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_out = '0;

  always @(negedge ce_clk) begin
    if (!ce_rst && prev_stall) begin
      chk("stall_hold", 64'({m_axis_data_tvalid, m_axis_data_tlast, m_axis_data_tdata}),
          64'({1'b1, prev_out}));
    end
    prev_stall = !ce_rst && m_axis_data_tvalid && !m_axis_data_tready;
    prev_out   = {m_axis_data_tlast, m_axis_data_tdata};
    if (!ce_rst && m_axis_data_tvalid && m_axis_data_tready)
      got_q.push_back({m_axis_data_tlast, m_axis_data_tdata});
  end

  task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge ce_clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    bit rdy;
    int t;
    t = 0;
    s_axis_data_tvalid = 1'b1; s_axis_data_tdata = d; s_axis_data_tlast = l;
    do begin
      @(negedge ce_clk); rdy = s_axis_data_tready;
      @(posedge ce_clk); #1; t++;
    end while (!rdy && t < 100);
    s_axis_data_tvalid = 1'b0;
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL send_beat timeout: tready stayed 0");
    end
  endtask

  task automatic wait_out(input int n, input string name);
    int t;
    t = 0;
    while (got_q.size() < n && t < 300) begin
      @(posedge ce_clk); t++;
    end
    #1;
    if (got_q.size() < n) begin
      checks++; failures++;
      $display("FAIL %s timeout: got %0d beats expected %0d", name, got_q.size(), n);
    end
  endtask

  task automatic pop_chk(input string name, input logic [32:0] exp);
    logic [32:0] v;
    if (got_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: no output beat, expected %0h", name, exp);
    end else begin
      v = got_q.pop_front();
      chk(name, 64'(v), 64'(exp));
    end
  endtask

  // Drives two beats of a 3-beat packet, then asserts reset between clock edges.
  task automatic midpkt_reset(input string name);
    m_axis_data_tready = 1'b1;
    s_axis_data_tvalid = 1'b1; s_axis_data_tdata = 32'h0001_0001; s_axis_data_tlast = 1'b0;
    @(posedge ce_clk); #1;
    s_axis_data_tdata = 32'h0002_0002;
    @(posedge ce_clk); #1;
    s_axis_data_tdata = 32'h0003_0003; s_axis_data_tlast = 1'b1;
    chk({name, "_pre_tvalid"}, 64'(m_axis_data_tvalid), 64'd1);
    #2 ce_rst = 1'b1;
    #1;
    chk({name, "_tvalid"}, 64'(m_axis_data_tvalid), 64'd0);
    chk({name, "_tready"}, 64'(s_axis_data_tready), 64'd0);
    chk({name, "_tdata"},  64'(m_axis_data_tdata),  64'd0);
    s_axis_data_tvalid = 1'b0; s_axis_data_tlast = 1'b0;
    @(posedge ce_clk); @(posedge ce_clk); #3;
    ce_rst = 1'b0;
    @(posedge ce_clk); #1;
    got_q.delete();
    chk({name, "_satcnt"}, 64'(sat_count), 64'd0);
  endtask

  typedef struct {
    logic        en;
    logic [15:0] level;
    logic [15:0] i;
    logic [15:0] q;
    logic [15:0] exp_i;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int sat_total;
    vecs[0] = '{1'b1, 16'h0100, 16'h0010, 16'h1234, 16'h0110, 1'b0};
    vecs[1] = '{1'b1, 16'h7000, 16'h2000, 16'h0001, 16'h7FFF, 1'b1};
    vecs[2] = '{1'b1, 16'h8000, 16'hF000, 16'h0002, 16'h8000, 1'b1};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h7FFF, 16'hABCD, 16'h7FFF, 1'b0};
    vecs[4] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0004, 16'hFFFF, 1'b0};
    vecs[5] = '{1'b1, 16'h0001, 16'h7FFE, 16'h0005, 16'h7FFF, 1'b0};
    vecs[6] = '{1'b1, 16'hFFFF, 16'h8000, 16'h0006, 16'h8000, 1'b1};
    vecs[7] = '{1'b1, 16'h8000, 16'h7FFF, 16'h0007, 16'hFFFF, 1'b0};
    vecs[8] = '{1'b0, 16'h8000, 16'h1234, 16'h8765, 16'h1234, 1'b0};

    #1 ce_rst = 1'b1;
    #11;
    chk("rst_tvalid", 64'(m_axis_data_tvalid), 64'd0);
    chk("rst_tdata",  64'(m_axis_data_tdata),  64'd0);
    chk("rst_tlast",  64'(m_axis_data_tlast),  64'd0);
    chk("rst_tready", 64'(s_axis_data_tready), 64'd0);
    chk("rst_satcnt", 64'(sat_count),          64'd0);
    @(posedge ce_clk); #3;
    ce_rst = 1'b0;
    @(posedge ce_clk); #1;
    chk("idle_tready", 64'(s_axis_data_tready), 64'd1);

    set_reg(A_CTRL, 32'h0000_0002);
    chk("clr_satcnt", 64'(sat_count), 64'd0);

    sat_total = 0;
    for (int k = 0; k < 9; k++) begin
      set_reg(A_LEVEL, {16'h0000, vecs[k].level});
      set_reg(A_CTRL, {31'd0, vecs[k].en});
      send_beat({vecs[k].i, vecs[k].q}, 1'b1);
      wait_out(1, $sformatf("vec%0d", k));
      pop_chk($sformatf("vec%0d", k), {1'b1, vecs[k].exp_i, vecs[k].q});
      @(posedge ce_clk); #1;
      if (vecs[k].exp_sat) sat_total++;
      chk($sformatf("vec%0d_satcnt", k), 64'(sat_count), CNT_EN ? 64'(sat_total) : 64'd0);
    end

    // Four back-to-back beats; first output two cycles after the first accept.
    set_reg(A_LEVEL, 32'h0000_0100);
    set_reg(A_CTRL, 32'h0000_0001);
    m_axis_data_tready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_axis_data_tvalid = 1'b1;
      s_axis_data_tdata  = {16'h0010, 16'h1234};
      s_axis_data_tlast  = (b == 3);
      @(negedge ce_clk);
      chk($sformatf("t1_rdy%0d", b), 64'(s_axis_data_tready), 64'd1);
      if (b == 1) chk("t1_lat1", 64'(m_axis_data_tvalid), 64'd0);
      if (b == 2) chk("t1_lat2", 64'(m_axis_data_tvalid), 64'd1);
      @(posedge ce_clk); #1;
    end
    s_axis_data_tvalid = 1'b0; s_axis_data_tlast = 1'b0;
    wait_out(4, "t1");
    for (int b = 0; b < 4; b++)
      pop_chk($sformatf("t1_beat%0d", b), {(b == 3), 16'h0110, 16'h1234});

    // Level changes mid-packet and coincident with the next packet's first accept.
    set_reg(A_LEVEL, 32'h0000_0002);
    begin
      logic       lasts[6];
      logic       stbs[6];
      logic [15:0] lvls[6];
      logic [15:0] exps[6];
      lasts = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      stbs  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      lvls  = '{16'h0, 16'h0005, 16'h0, 16'h0009, 16'h0, 16'h0};
      exps  = '{16'h0102, 16'h0102, 16'h0102, 16'h0105, 16'h0105, 16'h0109};
      for (int b = 0; b < 6; b++) begin
        s_axis_data_tvalid = 1'b1;
        s_axis_data_tdata  = {16'h0100, 16'(b)};
        s_axis_data_tlast  = lasts[b];
        set_stb  = stbs[b];
        set_addr = A_LEVEL;
        set_data = {16'h0000, lvls[b]};
        @(negedge ce_clk);
        chk($sformatf("t3_rdy%0d", b), 64'(s_axis_data_tready), 64'd1);
        @(posedge ce_clk); #1;
      end
      set_stb = 1'b0;
      s_axis_data_tvalid = 1'b0; s_axis_data_tlast = 1'b0;
      wait_out(6, "t3");
      for (int b = 0; b < 6; b++)
        pop_chk($sformatf("t3_beat%0d", b), {lasts[b], exps[b], 16'(b)});
    end

    // Random backpressure over 1000 beats of continuous input.
    set_reg(A_LEVEL, 32'h0000_0001);
    begin
      logic [32:0] exp_q[$];
      logic [31:0] cur;
      logic [15:0] ei;
      logic        lst;
      logic [32:0] v;
      int idx, cyc, bubbles, rdy_miss, errs;
      bit rdy;
      idx = 0; cyc = 0; bubbles = 0; rdy_miss = 0; errs = 0;
      cur = $urandom;
      if (cur[31:16] == 16'h7FFF) cur[31:16] = 16'h0000;
      while (idx < 1000 && cyc < 5000) begin
        lst = (idx % 8 == 7);
        s_axis_data_tvalid = 1'b1; s_axis_data_tdata = cur; s_axis_data_tlast = lst;
        m_axis_data_tready = ($urandom % 2 == 0);
        @(negedge ce_clk);
        rdy = s_axis_data_tready;
        if (cyc >= 3 && !m_axis_data_tvalid) bubbles++;
        if (m_axis_data_tready && !rdy) rdy_miss++;
        @(posedge ce_clk); #1;
        cyc++;
        if (rdy) begin
          ei = cur[31:16] + 16'd1;
          exp_q.push_back({lst, ei, cur[15:0]});
          idx++;
          cur = $urandom;
          if (cur[31:16] == 16'h7FFF) cur[31:16] = 16'h0000;
        end
      end
      s_axis_data_tvalid = 1'b0; s_axis_data_tlast = 1'b0;
      m_axis_data_tready = 1'b1;
      chk("t4_accepted", 64'(idx), 64'd1000);
      chk("t4_bubbles", 64'(bubbles), 64'd0);
      chk("t4_rdy_miss", 64'(rdy_miss), 64'd0);
      wait_out(1000, "t4");
      chk("t4_count", 64'(got_q.size()), 64'd1000);
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        v = got_q.pop_front();
        if (v !== exp_q[0] && errs == 0)
          $display("t4 first diff: got %0h expected %0h", v, exp_q[0]);
        if (v !== exp_q[0]) errs++;
        void'(exp_q.pop_front());
      end
      chk("t4_seq_errs", 64'(errs), 64'd0);
      got_q.delete();
    end

    // Reset mid-packet: settings fall back to level 0 / enable 0.
    set_reg(A_LEVEL, 32'h0000_0100);
    set_reg(A_CTRL, 32'h0000_0001);
    midpkt_reset("t6a");
    send_beat(32'h0010_0042, 1'b1);
    wait_out(1, "t6a_beat");
    pop_chk("t6a_beat", {1'b1, 32'h0010_0042});

    // Second reset mid-packet: the first beat afterwards must be treated as start of packet.
    set_reg(A_CTRL, 32'h0000_0001);
    midpkt_reset("t6b");
    set_reg(A_LEVEL, 32'h0000_0005);
    set_reg(A_CTRL, 32'h0000_0001);
    send_beat(32'h0010_0043, 1'b1);
    wait_out(1, "t6b_beat");
    pop_chk("t6b_beat", {1'b1, 32'h0015_0043});

    repeat (3) @(posedge ce_clk);
    #1;
    chk("end_no_extra", 64'(got_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
